// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: holding register, baud counter, bit counter and shift register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_datapath #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 load,
  input  logic                 enable_start,
  input  logic                 enable_count,
  input  logic                 tx_enable,
  output logic                 start_send,
  output logic                 byte_send,
  output logic                 tx_out,
  output logic                 busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOPB} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOPB} state_t;
`endif

  state_t                 state_q;
  logic [DATA_BITS-1:0]   hold_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [BAUD_W-1:0]      baud_q;
  logic [BIT_W-1:0]       bit_q;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif

  logic                   baud_end_d;
  logic [DATA_BITS-1:0]   send_byte_d;
  logic                   line_d;

  assign baud_end_d  = (baud_q == BAUD_LAST);
  // A load coinciding with enable_start bypasses straight into the shift register.
  assign send_byte_d = load ? tx_data : hold_q;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      shift_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            hold_q <= tx_data;
          end
          if (enable_start) begin
            state_q  <= START;
            shift_q  <= send_byte_d;
            baud_q   <= '0;
            bit_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^send_byte_d;
`endif
          end
        end

        START: begin
          if (!enable_start) begin
            state_q <= IDLE;
            baud_q  <= '0;
          end else if (baud_end_d) begin
            state_q <= DATA;
            baud_q  <= '0;
            bit_q   <= '0;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        DATA: begin
          if (!enable_count) begin
            state_q <= IDLE;
            baud_q  <= '0;
          end else if (baud_end_d) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOPB;
`endif
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (!enable_count) begin
            state_q <= IDLE;
            baud_q  <= '0;
          end else if (baud_end_d) begin
            state_q <= STOPB;
            baud_q  <= '0;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif

        STOPB: begin
          if (!enable_count || baud_end_d) begin
            state_q <= IDLE;
            baud_q  <= '0;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    line_d = 1'b1;
    case (state_q)
      START:  line_d = 1'b0;
      DATA:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: line_d = parity_q;
`endif
      default: line_d = 1'b1;
    endcase
  end

  // Pulses are gated by the tcu enables so an aborting cycle never reports completion.
  assign start_send = (state_q == START) && enable_start && baud_end_d;
  assign byte_send  = (state_q == STOPB) && enable_count && baud_end_d;
  assign tx_out     = tx_enable ? line_d : 1'b1;
  assign busy       = (state_q != IDLE);

endmodule
